// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse generator and the pulse-width measurement side.
package pulse_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} pgen_state_t;
    localparam int CLKS_PER_MS_DEFAULT = 50000;
endpackage

// File: rtl/ms_prescaler.sv
// Millisecond timebase: free-running counter with synchronous clear and a one-cycle tick at terminal count.
module ms_prescaler #(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_MS);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || count == TERM) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign tick = !clr && (count == TERM);
endmodule

// File: rtl/pulse_gen_ms.sv
// Programmable pulse-train generator: high time and gap in milliseconds, start/ready/done_tick handshake.
module pulse_gen_ms
    import pulse_pkg::*;
#(
    parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
    parameter int MS_W        = 32,
    parameter int REP_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [MS_W-1:0]  width_ms,
    input  logic [MS_W-1:0]  gap_ms,
    input  logic [REP_W-1:0] repeat_n,
    output logic             pulse_out,
    output logic             ready,
    output logic             busy,
    output logic             done_tick,
    output logic [REP_W-1:0] pulses_left,
    output logic [MS_W-1:0]  elapsed_ms
);
    localparam logic [MS_W-1:0]  MS_ONE  = MS_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    pgen_state_t     state;
    logic [MS_W-1:0] width_q;
    logic [MS_W-1:0] gap_q;
    logic [MS_W-1:0] elapsed_nxt;
    logic            ms_tick;
    logic            clr;

    // The prescaler is held at zero outside a timed phase, including the single
    // low cycle between back-to-back pulses when the gap is zero.
    assign clr = (state == IDLE) || (state == DONE) || abort ||
                 (state == HIGH && !pulse_out);
    assign elapsed_nxt = elapsed_ms + MS_ONE;

    ms_prescaler #(.CLKS_PER_MS(CLKS_PER_MS)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (ms_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pulse_out   <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done_tick   <= 1'b0;
            pulses_left <= '0;
            elapsed_ms  <= '0;
            width_q     <= '0;
            gap_q       <= '0;
        end else begin
            done_tick <= 1'b0;
            if (abort && state != IDLE) begin
                state       <= IDLE;
                pulse_out   <= 1'b0;
                ready       <= 1'b1;
                busy        <= 1'b0;
                pulses_left <= '0;
                elapsed_ms  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            width_q    <= width_ms;
                            gap_q      <= gap_ms;
                            elapsed_ms <= '0;
                            ready      <= 1'b0;
                            if (width_ms == '0 || repeat_n == '0) begin
                                state <= DONE;
                            end else begin
                                state       <= HIGH;
                                pulse_out   <= 1'b1;
                                busy        <= 1'b1;
                                pulses_left <= repeat_n;
                            end
                        end
                    end
                    HIGH: begin
                        if (!pulse_out) begin
                            pulse_out <= 1'b1;
                        end else if (ms_tick) begin
                            if (elapsed_nxt == width_q) begin
                                elapsed_ms  <= '0;
                                pulse_out   <= 1'b0;
                                pulses_left <= pulses_left - REP_ONE;
                                if (pulses_left == REP_ONE) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end else if (gap_q != '0) begin
                                    state <= LOW;
                                end
                            end else begin
                                elapsed_ms <= elapsed_nxt;
                            end
                        end
                    end
                    LOW: begin
                        if (ms_tick) begin
                            if (elapsed_nxt == gap_q) begin
                                elapsed_ms <= '0;
                                pulse_out  <= 1'b1;
                                state      <= HIGH;
                            end else begin
                                elapsed_ms <= elapsed_nxt;
                            end
                        end
                    end
                    DONE: begin
                        done_tick <= 1'b1;
                        pulse_out <= 1'b0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_gen_ms.sv
// Bench for pulse_gen_ms: table of train shapes, a timeline reference model with random trains, and hand-written abort/reset sequences.
module tb_pulse_gen_ms;
    localparam int CPM   = 4;
    localparam int MS_W  = 32;
    localparam int REP_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [MS_W-1:0]  width_ms;
    logic [MS_W-1:0]  gap_ms;
    logic [REP_W-1:0] repeat_n;
    logic             pulse_out;
    logic             ready;
    logic             busy;
    logic             done_tick;
    logic [REP_W-1:0] pulses_left;
    logic [MS_W-1:0]  elapsed_ms;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_gen_ms #(.CLKS_PER_MS(CPM), .MS_W(MS_W), .REP_W(REP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .width_ms    (width_ms),
        .gap_ms      (gap_ms),
        .repeat_n    (repeat_n),
        .pulse_out   (pulse_out),
        .ready       (ready),
        .busy        (busy),
        .done_tick   (done_tick),
        .pulses_left (pulses_left),
        .elapsed_ms  (elapsed_ms)
    );

    typedef struct {
        logic p, d, r, b;
        int   left;
        int   el;
    } exp_t;

    typedef struct {
        int w, g, n;
        int high_cycles, rises, done_at;
    } vec_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic p, input logic d, input logic r, input logic b,
                        input int left, input int el);
        exp_t e;
        e.p = p; e.d = d; e.r = r; e.b = b; e.left = left; e.el = el;
        exp_q.push_back(e);
    endtask

    // Cycle-by-cycle expected outputs for one train, starting one cycle after start is accepted.
    task automatic build_train(input int w, input int g, input int n);
        exp_q.delete();
        if (w == 0 || n == 0) begin
            push(0, 0, 0, 0, 0, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c < w * CPM; c++) push(1, 0, 0, 1, n - i, c / CPM);
                if (i < n - 1) begin
                    if (g == 0) push(0, 0, 0, 1, n - i - 1, 0);
                    else for (int c = 0; c < g * CPM; c++) push(0, 0, 0, 1, n - i - 1, c / CPM);
                end
            end
            push(0, 0, 0, 0, 0, 0);
        end
        push(0, 1, 1, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0);
    endtask

    // Called right after a falling edge with the DUT idle; returns in the same position.
    task automatic run_model(input int w, input int g, input int n, input bit noise);
        build_train(w, g, n);
        start = 1'b1; width_ms = w; gap_ms = g; repeat_n = REP_W'(n);
        foreach (exp_q[k]) begin
            @(negedge clk);
            check("train",
                  {pulse_out, done_tick, ready, busy, pulses_left, elapsed_ms},
                  {exp_q[k].p, exp_q[k].d, exp_q[k].r, exp_q[k].b,
                   REP_W'(exp_q[k].left), MS_W'(exp_q[k].el)});
            if (exp_q[k].r || !noise) begin
                start = 1'b0;
            end else begin
                start    = 1'($urandom_range(0, 1));
                width_ms = $urandom_range(0, 9);
                gap_ms   = $urandom_range(0, 9);
                repeat_n = REP_W'($urandom_range(0, 9));
            end
        end
        start = 1'b0;
    endtask

    task automatic measure(input int w, input int g, input int n,
                           output int high, output int rises, output int done_at, output int done_cnt);
        logic prev;
        prev = 1'b0; high = 0; rises = 0; done_at = -1; done_cnt = 0;
        start = 1'b1; width_ms = w; gap_ms = g; repeat_n = REP_W'(n);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (pulse_out) high++;
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
            if (done_tick) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 3) break;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int high, rises, done_at, done_cnt;
        vecs[0] = '{3, 2, 1, 12, 1, 14};
        vecs[1] = '{2, 1, 3, 24, 3, 34};
        vecs[2] = '{0, 1, 3,  0, 0,  2};
        vecs[3] = '{2, 1, 0,  0, 0,  2};
        vecs[4] = '{1, 0, 2,  8, 2, 11};
        vecs[5] = '{1, 3, 1,  4, 1,  6};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        width_ms = '0; gap_ms = '0; repeat_n = '0;
        #23;
        check("reset_state", {pulse_out, done_tick, ready, busy, pulses_left, elapsed_ms},
              {1'b0, 1'b0, 1'b1, 1'b0, REP_W'(0), MS_W'(0)});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            measure(vecs[i].w, vecs[i].g, vecs[i].n, high, rises, done_at, done_cnt);
            check($sformatf("high_cycles[%0d]", i), 64'(high), 64'(vecs[i].high_cycles));
            check($sformatf("rises[%0d]", i), 64'(rises), 64'(vecs[i].rises));
            check($sformatf("done_at[%0d]", i), 64'(done_at), 64'(vecs[i].done_at));
            check($sformatf("done_count[%0d]", i), 64'(done_cnt), 64'd1);
        end

        run_model(3, 2, 1, 1'b0);
        run_model(2, 1, 3, 1'b0);
        run_model(1, 0, 2, 1'b0);
        run_model(0, 2, 2, 1'b0);

        // Abort in the second HIGH cycle, then abort/start interplay in IDLE.
        start = 1'b1; width_ms = 5; gap_ms = 1; repeat_n = 2;
        @(negedge clk);
        start = 1'b0;
        check("abort_pre_high", 64'(pulse_out), 64'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", {pulse_out, done_tick, ready, busy, pulses_left, elapsed_ms},
              {1'b0, 1'b0, 1'b1, 1'b0, REP_W'(0), MS_W'(0)});
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_tick || pulse_out) done_cnt++;
        end
        check("abort_quiet", 64'(done_cnt), 64'd0);
        start = 1'b1; abort = 1'b1; width_ms = 2; repeat_n = 1;
        @(negedge clk);
        @(negedge clk);
        check("start_with_abort_ignored", {pulse_out, ready, busy, done_tick}, {1'b0, 1'b1, 1'b0, 1'b0});
        start = 1'b0; abort = 1'b0;
        run_model(1, 1, 1, 1'b0);

        // Re-pulsed start while busy must not alter the latched width.
        start = 1'b1; width_ms = 2; gap_ms = 1; repeat_n = 1;
        high = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pulse_out) high++;
            if (ready) start = 1'b0;
            else begin start = 1'b1; width_ms = 9; repeat_n = 5; end
        end
        start = 1'b0;
        check("restart_ignored_high", 64'(high), 64'd8);

        // Asynchronous reset in the middle of a pulse.
        start = 1'b1; width_ms = 3; gap_ms = 0; repeat_n = 2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pre_high", 64'(pulse_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {pulse_out, done_tick, ready, busy, pulses_left, elapsed_ms},
              {1'b0, 1'b0, 1'b1, 1'b0, REP_W'(0), MS_W'(0)});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_model(1, 1, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_model($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
